// File: rtl/param_tfhe_pkg.sv
// Active TFHE parameter set: LWE dimension and PBS batch size defaults.
package param_tfhe_pkg;
  localparam int LWE_K        = 887;
  localparam int BATCH_PBS_NB = 8;
endpackage

// File: rtl/pep_br_sched_pkg.sv
// Shared types and width helpers for the blind-rotation loop scheduler and its consumers.
package pep_br_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } br_sched_state_e;

  function automatic int br_loop_w(input int lwe_k);
    return (lwe_k > 1) ? $clog2(lwe_k) : 1;
  endfunction

  function automatic int nb_w(input int batch_pbs_nb);
    return $clog2(batch_pbs_nb + 1);
  endfunction

  localparam int PID_W_DEF     = 6;
  localparam int BR_LOOP_W_DEF = br_loop_w(param_tfhe_pkg::LWE_K);

  // Iteration token as seen by the BSK-fetch / CMUX pipeline.
  typedef struct packed {
    logic [PID_W_DEF-1:0]     pid;
    logic [BR_LOOP_W_DEF-1:0] br_loop;
    logic                     loop_first;
    logic                     loop_last;
    logic                     last;
  } br_iter_tok_t;

endpackage

// File: rtl/pep_br_credit_cnt.sv
// Inflight-token counter: +1 on issue, -1 on retire, with limit compare and underflow guard.
module pep_br_credit_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             below_limit,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A retire with nothing outstanding is dropped so the count never wraps.
  always_comb begin
    underflow = dec && (cnt_q == '0);
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else begin
      case ({inc, dec && !underflow})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt         = cnt_q;
  assign below_limit = (cnt_q < limit);

endmodule

// File: rtl/pep_br_loop_sched.sv
// Blind-rotation loop scheduler: issues nb*LWE_K (pid, br_loop) tokens loop-major, pid-minor.
// state | meaning
// IDLE  | waiting for a batch command
// RUN   | issuing tokens while inflight < nb
// DRAIN | all tokens issued, waiting for retirements
// DONE  | one-cycle batch_done pulse
module pep_br_loop_sched
  import pep_br_sched_pkg::*;
#(
  parameter int LWE_K        = param_tfhe_pkg::LWE_K,
  parameter int BATCH_PBS_NB = param_tfhe_pkg::BATCH_PBS_NB,
  parameter int PID_W        = 6,
  parameter int BR_LOOP_W    = br_loop_w(LWE_K),
  parameter int NB_W         = nb_w(BATCH_PBS_NB)
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 cmd_vld,
  output logic                 cmd_rdy,
  input  logic [NB_W-1:0]      cmd_pbs_nb,
  input  logic [PID_W-1:0]     cmd_pid_base,
  output logic                 iter_vld,
  input  logic                 iter_rdy,
  output logic [PID_W-1:0]     iter_pid,
  output logic [BR_LOOP_W-1:0] iter_br_loop,
  output logic                 iter_loop_first,
  output logic                 iter_loop_last,
  output logic                 iter_last,
  input  logic                 done_vld,
  output logic                 batch_done,
  output logic                 busy,
  output logic                 err
);

  br_sched_state_e      state_q, state_d;
  logic [NB_W-1:0]      nb_q, nb_d;
  logic [PID_W-1:0]     pid_base_q, pid_base_d;
  logic [NB_W-1:0]      pbs_idx_q, pbs_idx_d;
  logic [BR_LOOP_W-1:0] br_loop_q, br_loop_d;
  logic                 err_q, err_d;

  logic [NB_W-1:0] inflight;
  logic            below_limit;
  logic            underflow;
  logic            hs;
  logic            cmd_legal;
  logic            cmd_take;
  logic            loop_last;
  logic            br_last;

  assign hs        = iter_vld && iter_rdy;
  assign cmd_legal = (cmd_pbs_nb != '0) && (cmd_pbs_nb <= NB_W'(BATCH_PBS_NB));
  assign cmd_take  = cmd_vld && (state_q == IDLE);
  assign loop_last = (pbs_idx_q == nb_q - NB_W'(1));
  assign br_last   = (br_loop_q == BR_LOOP_W'(LWE_K - 1));

  pep_br_credit_cnt #(
    .CNT_W(NB_W)
  ) u_credit (
    .clk        (clk),
    .a_rst      (a_rst),
    .clr        (cmd_take),
    .inc        (hs),
    .dec        (done_vld),
    .limit      (nb_q),
    .cnt        (inflight),
    .below_limit(below_limit),
    .underflow  (underflow)
  );

  always_comb begin
    state_d    = state_q;
    nb_d       = nb_q;
    pid_base_d = pid_base_q;
    pbs_idx_d  = pbs_idx_q;
    br_loop_d  = br_loop_q;
    err_d      = underflow;
    case (state_q)
      IDLE: begin
        if (cmd_take) begin
          if (cmd_legal) begin
            nb_d       = cmd_pbs_nb;
            pid_base_d = cmd_pid_base;
            pbs_idx_d  = '0;
            br_loop_d  = '0;
            state_d    = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          if (loop_last) begin
            pbs_idx_d = '0;
            if (br_last) state_d = DRAIN;
            else         br_loop_d = br_loop_q + BR_LOOP_W'(1);
          end else begin
            pbs_idx_d = pbs_idx_q + NB_W'(1);
          end
        end
      end
      DRAIN: begin
        if (inflight == '0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q    <= IDLE;
      nb_q       <= '0;
      pid_base_q <= '0;
      pbs_idx_q  <= '0;
      br_loop_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      pid_base_q <= pid_base_d;
      pbs_idx_q  <= pbs_idx_d;
      br_loop_q  <= br_loop_d;
      err_q      <= err_d;
    end
  end

  // Every output below depends only on registered state.
  assign cmd_rdy         = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign batch_done      = (state_q == DONE);
  assign err             = err_q;
  assign iter_vld        = (state_q == RUN) && below_limit;
  assign iter_pid        = pid_base_q + PID_W'(pbs_idx_q);
  assign iter_br_loop    = br_loop_q;
  assign iter_loop_first = (pbs_idx_q == '0);
  assign iter_loop_last  = loop_last;
  assign iter_last       = br_last;

endmodule

// File: tb/tb_pep_br_loop_sched.sv
// Self-checking bench for pep_br_loop_sched with LWE_K=4 and a delayed in-order datapath model.
module tb_pep_br_loop_sched;

  localparam int K      = 4;
  localparam int BNB    = 8;
  localparam int PW     = 6;
  localparam int BW     = 2;
  localparam int NW     = 4;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          a_rst = 1'b0;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [NW-1:0] cmd_pbs_nb = '0;
  logic [PW-1:0] cmd_pid_base = '0;
  logic          iter_vld;
  logic          iter_rdy = 1'b0;
  logic [PW-1:0] iter_pid;
  logic [BW-1:0] iter_br_loop;
  logic          iter_loop_first;
  logic          iter_loop_last;
  logic          iter_last;
  logic          done_vld = 1'b0;
  logic          batch_done;
  logic          busy;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;
  int q_due[$];

  always #5 clk = ~clk;

  pep_br_loop_sched #(
    .LWE_K       (K),
    .BATCH_PBS_NB(BNB),
    .PID_W       (PW)
  ) dut (
    .clk            (clk),
    .a_rst          (a_rst),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_pbs_nb     (cmd_pbs_nb),
    .cmd_pid_base   (cmd_pid_base),
    .iter_vld       (iter_vld),
    .iter_rdy       (iter_rdy),
    .iter_pid       (iter_pid),
    .iter_br_loop   (iter_br_loop),
    .iter_loop_first(iter_loop_first),
    .iter_loop_last (iter_loop_last),
    .iter_last      (iter_last),
    .done_vld       (done_vld),
    .batch_done     (batch_done),
    .busy           (busy),
    .err            (err)
  );

  // Runs one batch against an in-order datapath that retires each token `delay` cycles
  // after issue. Expected tokens come from the loop-major / pid-minor enumeration.
  task automatic drive_batch(input int nb, input int base, input int delay,
                             input int stall_pct, input int abort_after);
    int total, issued, retired, cyc, done_at, t;
    bit fin;
    logic exp_vld, exp_busy, exp_bd;
    logic [PW-1:0] e_pid;
    logic [BW-1:0] e_loop;
    total = nb * K; issued = 0; retired = 0; cyc = 0; done_at = -1; fin = 0;
    q_due.delete();
    @(negedge clk);
    n_chk++;
    if (cmd_rdy !== 1'b1) begin
      n_fail++; $display("FAIL cmd_rdy_before_batch got=%0b exp=1", cmd_rdy);
    end
    cmd_vld = 1'b1; cmd_pbs_nb = NW'(nb); cmd_pid_base = PW'(base);
    @(negedge clk);
    cmd_vld = 1'b0;
    while (!fin) begin
      if (abort_after >= 0 && issued == abort_after) begin
        a_rst = 1'b1; iter_rdy = 1'b0; done_vld = 1'b0;
        #1;
        n_chk++;
        if (iter_vld !== 1'b0) begin
          n_fail++; $display("FAIL iter_vld_in_reset got=%0b exp=0", iter_vld);
        end
        n_chk++;
        if (busy !== 1'b0) begin
          n_fail++; $display("FAIL busy_in_reset got=%0b exp=0", busy);
        end
        @(negedge clk); @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (cmd_rdy !== 1'b1) begin
          n_fail++; $display("FAIL cmd_rdy_after_reset got=%0b exp=1", cmd_rdy);
        end
        q_due.delete();
        return;
      end
      exp_vld  = (issued < total) && ((issued - retired) < nb);
      exp_busy = (done_at < 0) || (cyc <= done_at);
      exp_bd   = (cyc == done_at);
      n_chk++;
      if (iter_vld !== exp_vld) begin
        n_fail++; $display("FAIL iter_vld cyc=%0d got=%0b exp=%0b", cyc, iter_vld, exp_vld);
      end
      n_chk++;
      if (batch_done !== exp_bd) begin
        n_fail++; $display("FAIL batch_done cyc=%0d got=%0b exp=%0b", cyc, batch_done, exp_bd);
      end
      n_chk++;
      if (busy !== exp_busy || cmd_rdy !== !exp_busy) begin
        n_fail++;
        $display("FAIL busy_cmd_rdy cyc=%0d got=%0b/%0b exp=%0b/%0b", cyc, busy, cmd_rdy, exp_busy, !exp_busy);
      end
      n_chk++;
      if (err !== 1'b0) begin
        n_fail++; $display("FAIL err_in_batch cyc=%0d got=%0b exp=0", cyc, err);
      end
      n_chk++;
      if ((issued - retired) > nb) begin
        n_fail++; $display("FAIL inflight_bound cyc=%0d got=%0d exp<=%0d", cyc, issued - retired, nb);
      end
      if (exp_vld && iter_vld) begin
        t      = issued;
        e_pid  = PW'((base + (t % nb)) % 64);
        e_loop = BW'(t / nb);
        n_chk++;
        if (iter_pid !== e_pid || iter_br_loop !== e_loop) begin
          n_fail++;
          $display("FAIL token_id t=%0d got=pid%0d/loop%0d exp=pid%0d/loop%0d", t, iter_pid, iter_br_loop, e_pid, e_loop);
        end
        n_chk++;
        if (iter_loop_first !== ((t % nb) == 0) || iter_loop_last !== ((t % nb) == nb - 1)
            || iter_last !== ((t / nb) == K - 1)) begin
          n_fail++;
          $display("FAIL token_flags t=%0d got=%0b%0b%0b exp=%0b%0b%0b", t, iter_loop_first, iter_loop_last,
                   iter_last, (t % nb) == 0, (t % nb) == nb - 1, (t / nb) == K - 1);
        end
      end
      iter_rdy = ($urandom_range(99) >= stall_pct);
      done_vld = 1'b0;
      if (iter_vld && iter_rdy) begin
        q_due.push_back(cyc + delay);
        issued++;
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        done_vld = 1'b1;
        void'(q_due.pop_front());
        retired++;
        if (retired == total) done_at = cyc + 2;
      end
      if (done_at >= 0 && cyc == done_at + 1) fin = 1;
      if (cyc > BUDGET) begin
        n_chk++; n_fail++;
        $display("FAIL batch_timeout got=issued%0d/retired%0d exp=%0d", issued, retired, total);
        fin = 1;
      end
      cyc++;
      @(negedge clk);
    end
    iter_rdy = 1'b0; done_vld = 1'b0;
    n_chk++;
    if (issued != total || retired != total) begin
      n_fail++; $display("FAIL token_total got=%0d/%0d exp=%0d", issued, retired, total);
    end
  endtask

  task automatic test_reset();
    #1 a_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (cmd_rdy !== 1'b1 || iter_vld !== 1'b0 || busy !== 1'b0 || batch_done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got=rdy%0b vld%0b busy%0b bd%0b err%0b exp=rdy1 vld0 busy0 bd0 err0",
               cmd_rdy, iter_vld, busy, batch_done, err);
    end
    a_rst = 1'b0;
  endtask

  task automatic test_single_pbs();
    drive_batch(1, 5, 3, 0, -1);
  endtask

  task automatic test_full_batch_stalls();
    drive_batch(8, 62, 20, 30, -1);
  endtask

  task automatic test_same_cycle_retire();
    drive_batch(3, int'($urandom_range(63)), 2, 0, -1);
  endtask

  task automatic test_illegal_cmd();
    logic [NW-1:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmd_vld = 1'b1; cmd_pbs_nb = bad[i]; cmd_pid_base = PW'($urandom_range(63));
      @(negedge clk);
      cmd_vld = 1'b0;
      n_chk++;
      if (err !== 1'b1 || busy !== 1'b0 || iter_vld !== 1'b0 || cmd_rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_nb%0d got=err%0b busy%0b vld%0b rdy%0b exp=err1 busy0 vld0 rdy1",
                 bad[i], err, busy, iter_vld, cmd_rdy);
      end
      @(negedge clk);
      n_chk++;
      if (err !== 1'b0 || busy !== 1'b0 || iter_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_after_nb%0d got=err%0b busy%0b vld%0b exp=err0 busy0 vld0", bad[i], err, busy, iter_vld);
      end
    end
  endtask

  task automatic test_spurious_done();
    @(negedge clk);
    done_vld = 1'b1;
    @(negedge clk);
    done_vld = 1'b0;
    n_chk++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL spurious_done got=err%0b busy%0b exp=err1 busy0", err, busy);
    end
    @(negedge clk);
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL spurious_done_pulse got=%0b exp=0", err);
    end
    drive_batch(2, int'($urandom_range(63)), 5, 20, -1);
  endtask

  task automatic test_reset_mid_batch();
    drive_batch(8, int'($urandom_range(63)), 20, 0, 10);
    drive_batch(8, int'($urandom_range(63)), int'($urandom_range(1, 20)), 25, -1);
  endtask

  task automatic test_random_batches();
    for (int b = 0; b < 5; b++) begin
      drive_batch(int'($urandom_range(1, BNB)), int'($urandom_range(63)), int'($urandom_range(1, 25)),
                  int'($urandom_range(0, 50)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_single_pbs();
    test_full_batch_stalls();
    test_same_cycle_retire();
    test_illegal_cmd();
    test_spurious_done();
    test_reset_mid_batch();
    test_random_batches();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
